// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU data port and a DMA/debug loader port.
// Latency: 0 cycles; grant and read data are combinational, a write commits at the edge ending its grant cycle.
// Backpressure: CPU has priority and sees cpu_stall when denied; DMA is forced in after STARVE_LIMIT contended cycles, with bursts capped at MAX_BURST.
module dmem_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic [DW-1:0] rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner
);

    localparam int WW = $clog2(STARVE_LIMIT) + 1;
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [WW-1:0] WAIT_LAST  = WW'(STARVE_LIMIT - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    typedef enum logic {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          gnt_dma;
    logic          gnt_cpu;

    // Grant decision: DMA wins when it owns the memory or the CPU is idle; nothing is granted while reset is low.
    always_comb begin
        gnt_dma = reset & dma_req & ((state_q == S_DMA) | ~cpu_req);
        gnt_cpu = reset & cpu_req & ~gnt_dma;
    end

    assign cpu_stall = reset & cpu_req & ~gnt_cpu;
    assign dma_gnt   = gnt_dma;
    assign rdata     = mem_rdata;
    assign owner     = (state_q == S_DMA);

    // Memory port mux: the DMA side drives only when granted; otherwise CPU address/data, write gated by its grant.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we & gnt_cpu;
        if (gnt_dma) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
        end
    end

    // Ownership FSM: count contended CPU wins to bound DMA starvation, count DMA grants to bound the burst.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        burst_d = burst_q;
        case (state_q)
            S_CPU: begin
                if (cpu_req && dma_req) begin
                    if (wait_q == WAIT_LAST) begin
                        state_d = S_DMA;
                        wait_d  = '0;
                        burst_d = '0;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end else begin
                    wait_d = '0;
                end
            end
            S_DMA: begin
                if (dma_req) begin
                    if (burst_q == BURST_LAST) begin
                        state_d = S_CPU;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + BW'(1);
                    end
                end else begin
                    state_d = S_CPU;
                    burst_d = '0;
                end
            end
            default: begin
                state_d = S_CPU;
                wait_d  = '0;
                burst_d = '0;
            end
        endcase
    end

    // State registers; reset returns ownership to the CPU and clears both counters immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_CPU;
            wait_q  <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            burst_q <= burst_d;
        end
    end

endmodule
